// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_e;

  // Which priority case drives the pipeline controls this cycle
  typedef enum logic [2:0] {
    HZ_RESET,
    HZ_HOLD,
    HZ_REDIRECT,
    HZ_LOAD_USE,
    HZ_MDU,
    HZ_RUN
  } hz_case_e;

  localparam int REG_ZERO = 0;

  function automatic int mdu_timer_w(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// rtl/mdu_busy_timer.sv - MDU occupancy timer; busy while the count is non-zero
module mdu_busy_timer
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int TW = mdu_timer_w(MDU_CYCLES);

  logic [TW-1:0] timer_q, timer_d;
  hz_state_e     state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
      state_q <= RUN;
    end else begin
      timer_q <= timer_d;
      state_q <= state_d;
    end
  end

  // A load in the same cycle as the final decrement wins
  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = TW'(MDU_CYCLES - 1);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
    state_d = (timer_d != '0) ? MDU_BUSY : RUN;
  end

  always_comb begin
    busy = (state_q == MDU_BUSY);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / MDU / redirect hazard controller with stall counter
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 16,
  parameter int REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             id_mdu_use,
  input  logic             ex_MemR,
  input  logic [REG_W-1:0] ex_reg_rd,
  input  logic             ex_redirect,
  input  logic             mem_hold,
  output logic             PC_WR,
  output logic             IF_ID_WR,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_WR,
  output logic             ID_EX_FLUSH,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             timer_busy;
  logic             lu_hit;
  logic             mdu_hit;
  logic             mdu_load;
  hz_case_e         hz_case;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  mdu_busy_timer #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (mdu_load),
    .busy (timer_busy)
  );

  always_comb begin
    lu_hit  = ex_MemR && (ex_reg_rd != REG_W'(REG_ZERO)) &&
              ((id_uses_rs && (id_rs == ex_reg_rd)) || (id_uses_rt && (id_rt == ex_reg_rd)));
    mdu_hit = timer_busy && id_mdu_use;
    if (!rst_n)           hz_case = HZ_RESET;
    else if (mem_hold)    hz_case = HZ_HOLD;
    else if (ex_redirect) hz_case = HZ_REDIRECT;
    else if (lu_hit)      hz_case = HZ_LOAD_USE;
    else if (mdu_hit)     hz_case = HZ_MDU;
    else                  hz_case = HZ_RUN;
  end

  always_comb begin
    PC_WR       = 1'b0;
    IF_ID_WR    = 1'b0;
    IF_ID_FLUSH = 1'b0;
    ID_EX_WR    = 1'b0;
    ID_EX_FLUSH = 1'b0;
    case (hz_case)
      HZ_REDIRECT: begin
        PC_WR       = 1'b1;
        IF_ID_WR    = 1'b1;
        IF_ID_FLUSH = 1'b1;
        ID_EX_WR    = 1'b1;
        ID_EX_FLUSH = 1'b1;
      end
      HZ_LOAD_USE, HZ_MDU: begin
        ID_EX_WR    = 1'b1;
        ID_EX_FLUSH = 1'b1;
      end
      HZ_RUN: begin
        PC_WR    = 1'b1;
        IF_ID_WR = 1'b1;
        ID_EX_WR = 1'b1;
      end
      default: ;
    endcase
  end

  // Only an MDU op that really moves into EX starts the timer; redirect squashes it
  always_comb begin
    mdu_load = (hz_case == HZ_RUN) && id_mdu_start;
    mdu_busy = rst_n && timer_busy;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((hz_case == HZ_LOAD_USE) || (hz_case == HZ_MDU)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CYC_A = 4;
  localparam int CYC_B = 12;
  localparam int CNT_A = 16;
  localparam int CNT_B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_reg_rd;
  logic       id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_use;
  logic       ex_MemR, ex_redirect, mem_hold;

  logic             pc_a, ifwr_a, iffl_a, exwr_a, exfl_a, busy_a;
  logic             pc_b, ifwr_b, iffl_b, exwr_b, exfl_b, busy_b;
  logic [CNT_A-1:0] st_a;
  logic [CNT_B-1:0] st_b;

  typedef struct packed {
    logic [4:0] ctl_a;
    logic [4:0] ctl_b;
    logic       busy_a;
    logic       busy_b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tmr_a = 0, tmr_b = 0, cnt_a = 0, cnt_b = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_CYCLES(CYC_A), .CNT_W(CNT_A), .REG_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_use(id_mdu_use),
    .ex_MemR(ex_MemR), .ex_reg_rd(ex_reg_rd), .ex_redirect(ex_redirect), .mem_hold(mem_hold),
    .PC_WR(pc_a), .IF_ID_WR(ifwr_a), .IF_ID_FLUSH(iffl_a), .ID_EX_WR(exwr_a),
    .ID_EX_FLUSH(exfl_a), .mdu_busy(busy_a), .stall_cycles(st_a)
  );

  pipe_hazard_ctrl #(.MDU_CYCLES(CYC_B), .CNT_W(CNT_B), .REG_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_use(id_mdu_use),
    .ex_MemR(ex_MemR), .ex_reg_rd(ex_reg_rd), .ex_redirect(ex_redirect), .mem_hold(mem_hold),
    .PC_WR(pc_b), .IF_ID_WR(ifwr_b), .IF_ID_FLUSH(iffl_b), .ID_EX_WR(exwr_b),
    .ID_EX_FLUSH(exfl_b), .mdu_busy(busy_b), .stall_cycles(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 reset, 1 hold, 2 redirect, 3 load-use, 4 mdu, 5 run
  function automatic int hcase(input bit busy);
    if (!rst_n) return 0;
    if (mem_hold) return 1;
    if (ex_redirect) return 2;
    if (ex_MemR && ex_reg_rd != 5'd0 &&
        ((id_uses_rs && id_rs == ex_reg_rd) || (id_uses_rt && id_rt == ex_reg_rd))) return 3;
    if (busy && id_mdu_use) return 4;
    return 5;
  endfunction

  // {PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_WR, ID_EX_FLUSH}
  function automatic logic [4:0] ctl(input int c);
    case (c)
      2:       return 5'b11111;
      3, 4:    return 5'b00011;
      5:       return 5'b11010;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic upd(inout int tmr, inout int cnt, input int cyc_n, input int cmax, input int c);
    if (c == 0) begin
      tmr = 0;
      cnt = 0;
    end else begin
      if (c == 5 && id_mdu_start) tmr = cyc_n - 1;
      else if (tmr > 0) tmr = tmr - 1;
      if ((c == 3 || c == 4) && cnt < cmax) cnt = cnt + 1;
    end
  endtask

  task automatic clear();
    id_rs = 5'd0; id_rt = 5'd0; ex_reg_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_start = 1'b0; id_mdu_use = 1'b0;
    ex_MemR = 1'b0; ex_redirect = 1'b0; mem_hold = 1'b0;
  endtask

  // Called just after a negedge with inputs already driven; returns just after the next negedge
  task automatic cyc(input string tag);
    exp_t e;
    int   ca, cb;
    ca = hcase(tmr_a > 0);
    cb = hcase(tmr_b > 0);
    e.ctl_a  = ctl(ca);
    e.ctl_b  = ctl(cb);
    e.busy_a = rst_n && (tmr_a > 0);
    e.busy_b = rst_n && (tmr_b > 0);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, "_ctl_a"}, 32'({pc_a, ifwr_a, iffl_a, exwr_a, exfl_a}), 32'(e.ctl_a));
    chk({tag, "_ctl_b"}, 32'({pc_b, ifwr_b, iffl_b, exwr_b, exfl_b}), 32'(e.ctl_b));
    chk({tag, "_busy_a"}, 32'(busy_a), 32'(e.busy_a));
    chk({tag, "_busy_b"}, 32'(busy_b), 32'(e.busy_b));
    @(posedge clk);
    upd(tmr_a, cnt_a, CYC_A, (1 << CNT_A) - 1, ca);
    upd(tmr_b, cnt_b, CYC_B, (1 << CNT_B) - 1, cb);
    #1;
    chk({tag, "_cnt_a"}, 32'(st_a), 32'(cnt_a));
    chk({tag, "_cnt_b"}, 32'(st_b), 32'(cnt_b));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear();
    @(negedge clk);
    cyc("rst0");
    ex_MemR = 1'b1; ex_reg_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1; id_mdu_start = 1'b1;
    cyc("rst_forced");

    rst_n = 1'b1;
    clear();
    cyc("idle");

    ex_MemR = 1'b1; ex_reg_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    cyc("lu_rs");
    chk("lu_rs_const", 32'(st_a), 32'd1);
    clear(); id_rs = 5'd5; id_uses_rs = 1'b1;
    cyc("lu_after");

    ex_MemR = 1'b1; ex_reg_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    cyc("lw_r0");
    ex_MemR = 1'b1; ex_reg_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
    cyc("lu_rt");
    clear(); ex_MemR = 1'b1; ex_reg_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9;
    cyc("lu_nouse");
    clear(); ex_reg_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
    cyc("no_load");

    clear(); id_mdu_start = 1'b1; id_mdu_use = 1'b1;
    cyc("mult");
    id_mdu_start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mfhi");
    chk("mult_stalls_const", 32'(st_a), 32'd5);
    clear();
    for (int i = 0; i < 10; i++) cyc("drain");

    ex_redirect = 1'b1; ex_MemR = 1'b1; ex_reg_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
    id_mdu_start = 1'b1; id_mdu_use = 1'b1;
    cyc("redirect");
    chk("redirect_no_load", 32'(busy_a), 32'd0);
    clear();
    cyc("post_redirect");

    id_mdu_start = 1'b1; id_mdu_use = 1'b1;
    cyc("mult2");
    clear();
    cyc("mult2_gap");
    mem_hold = 1'b1; id_mdu_use = 1'b1;
    cyc("hold1");
    cyc("hold2");
    chk("hold_busy_fell", 32'(busy_a), 32'd0);

    clear();
    for (int i = 0; i < 12; i++) cyc("drain2");
    id_mdu_start = 1'b1; id_mdu_use = 1'b1;
    cyc("mult3");
    clear();
    cyc("mult3_gap");
    chk("b_busy_mid", 32'(busy_b), 32'd1);
    rst_n = 1'b0;
    cyc("rst_mid");
    chk("rst_mid_cnt_b", 32'(st_b), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_busy_b", 32'(busy_b), 32'd0);

    ex_MemR = 1'b1; ex_reg_rd = 5'd6; id_rs = 5'd6; id_uses_rs = 1'b1;
    for (int i = 0; i < 5; i++) cyc("sat");
    chk("sat_b_const", 32'(st_b), 32'd3);
    chk("sat_a_const", 32'(st_a), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
